// File: rtl/factorial_ctrl.sv
// Sequencing FSM for the 8-bit factorial datapath: loads n, 1 and the constant 1,
// then alternates acc*=k / k-=1 until k reaches 1 and latches acc into the output register.
module factorial_ctrl #(
    parameter int         WIDTH    = 8,
    parameter logic [2:0] OP_PASSA = 3'b000,
    parameter logic [2:0] OP_SUB   = 3'b010,
    parameter logic [2:0] OP_MUL   = 3'b011
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] n_i,
    input  logic             compare,
    output logic [WIDTH-1:0] Data_i,
    output logic             IE,
    output logic             we,
    output logic [1:0]       wa,
    output logic             rea,
    output logic             reb,
    output logic [1:0]       raa,
    output logic [1:0]       rab,
    output logic [2:0]       Sel_alu,
    output logic             OE,
    output logic             busy,
    output logic             done
);

    // state    | meaning
    // IDLE     | waiting for start
    // LOAD_N   | R0 (k) <= n
    // LOAD_ONE | R1 (acc) <= 1
    // LOAD_K   | R2 <= constant 1
    // CHECK    | ALU passes k; leave loop when k == 1 or n <= 1
    // MUL      | acc <= acc * k
    // DEC      | k <= k - 1
    // OUTPUT   | ALU passes acc into the output register
    // DONE     | result valid, one-cycle done pulse
    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_LOAD_N   = 4'd1,
        S_LOAD_ONE = 4'd2,
        S_LOAD_K   = 4'd3,
        S_CHECK    = 4'd4,
        S_MUL      = 4'd5,
        S_DEC      = 4'd6,
        S_OUTPUT   = 4'd7,
        S_DONE     = 4'd8
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] n_q;
    logic             z_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            n_q   <= '0;
            z_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && start) begin
                n_q <= n_i;
                z_q <= (n_i <= WIDTH'(1));
            end
        end
    end

    always_comb begin
        state_nxt = S_IDLE;
        Data_i    = '0;
        IE        = 1'b0;
        we        = 1'b0;
        wa        = 2'd0;
        rea       = 1'b0;
        reb       = 1'b0;
        raa       = 2'd0;
        rab       = 2'd0;
        Sel_alu   = OP_PASSA;
        OE        = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                busy      = 1'b0;
                state_nxt = start ? S_LOAD_N : S_IDLE;
            end
            S_LOAD_N: begin
                IE        = 1'b1;
                Data_i    = n_q;
                we        = 1'b1;
                wa        = 2'd0;
                state_nxt = S_LOAD_ONE;
            end
            S_LOAD_ONE: begin
                IE        = 1'b1;
                Data_i    = WIDTH'(1);
                we        = 1'b1;
                wa        = 2'd1;
                state_nxt = S_LOAD_K;
            end
            S_LOAD_K: begin
                IE        = 1'b1;
                Data_i    = WIDTH'(1);
                we        = 1'b1;
                wa        = 2'd2;
                state_nxt = S_CHECK;
            end
            S_CHECK: begin
                rea       = 1'b1;
                raa       = 2'd0;
                Sel_alu   = OP_PASSA;
                // z_q covers n = 0, where k never reaches 1
                state_nxt = (compare || z_q) ? S_OUTPUT : S_MUL;
            end
            S_MUL: begin
                rea       = 1'b1;
                reb       = 1'b1;
                raa       = 2'd1;
                rab       = 2'd0;
                Sel_alu   = OP_MUL;
                we        = 1'b1;
                wa        = 2'd1;
                state_nxt = S_DEC;
            end
            S_DEC: begin
                rea       = 1'b1;
                reb       = 1'b1;
                raa       = 2'd0;
                rab       = 2'd2;
                Sel_alu   = OP_SUB;
                we        = 1'b1;
                wa        = 2'd0;
                state_nxt = S_CHECK;
            end
            S_OUTPUT: begin
                rea       = 1'b1;
                raa       = 2'd1;
                Sel_alu   = OP_PASSA;
                OE        = 1'b1;
                state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                busy      = 1'b0;
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_factorial_ctrl.sv
// Bench for factorial_ctrl: behavioural datapath, cycle-schedule reference model,
// literal latency/result checks and randomized runs.
module tb_factorial_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [7:0] n_i = 8'd0;
    logic       compare;
    logic [7:0] Data_i;
    logic       IE, we, rea, reb, OE, busy, done;
    logic [1:0] wa, raa, rab;
    logic [2:0] Sel_alu;

    int checks = 0;
    int errors = 0;

    factorial_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .n_i(n_i), .compare(compare),
        .Data_i(Data_i), .IE(IE), .we(we), .wa(wa), .rea(rea), .reb(reb),
        .raa(raa), .rab(rab), .Sel_alu(Sel_alu), .OE(OE), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // behavioural datapath: register file, ALU, compare-with-1, output register
    logic [7:0] rf [4];
    logic [7:0] alu_a, alu_b, alu_o, out_q;

    always_comb begin
        alu_a = rea ? rf[raa] : 8'd0;
        alu_b = reb ? rf[rab] : 8'd0;
        case (Sel_alu)
            3'b010:  alu_o = alu_a - alu_b;
            3'b011:  alu_o = 8'((16'(alu_a) * 16'(alu_b)));
            default: alu_o = alu_a;
        endcase
    end
    assign compare = (alu_o == 8'd1);

    always @(posedge clk) begin
        if (we) rf[wa] <= IE ? Data_i : alu_o;
        if (OE) out_q <= alu_o;
    end

    function automatic int fact_mod(input int n);
        int r = 1;
        for (int i = 2; i <= n; i++) r = (r * i) % 256;
        return r;
    endfunction

    function automatic int run_len(input int n);
        return (n <= 1) ? 6 : 3 * n + 3;
    endfunction

    // expected control vector from the position in the run's cycle schedule
    function automatic logic [23:0] exp_vec(input int ph, input int len, input int n);
        logic [7:0] d;
        logic       ie_e, we_e, rea_e, reb_e, oe_e, bz_e, dn_e;
        logic [1:0] wa_e, raa_e, rab_e;
        logic [2:0] sel_e;
        int         r;
        d = 8'd0; ie_e = 0; we_e = 0; rea_e = 0; reb_e = 0; oe_e = 0; bz_e = 0; dn_e = 0;
        wa_e = 0; raa_e = 0; rab_e = 0; sel_e = 0;
        if (ph != 0) bz_e = 1;
        if (ph == 1) begin
            ie_e = 1; d = 8'(n); we_e = 1; wa_e = 2'd0;
        end else if (ph == 2 || ph == 3) begin
            ie_e = 1; d = 8'd1; we_e = 1; wa_e = 2'(ph - 1);
        end else if (ph != 0 && ph == len) begin
            dn_e = 1;
        end else if (ph != 0 && ph == len - 1) begin
            rea_e = 1; raa_e = 2'd1; oe_e = 1;
        end else if (ph != 0) begin
            r = (ph - 4) % 3;
            if (r == 1) begin
                rea_e = 1; reb_e = 1; raa_e = 2'd1; rab_e = 2'd0; sel_e = 3'b011; we_e = 1; wa_e = 2'd1;
            end else if (r == 2) begin
                rea_e = 1; reb_e = 1; raa_e = 2'd0; rab_e = 2'd2; sel_e = 3'b010; we_e = 1; wa_e = 2'd0;
            end else begin
                rea_e = 1; raa_e = 2'd0;
            end
        end
        return {d, ie_e, we_e, wa_e, rea_e, reb_e, raa_e, rab_e, sel_e, oe_e, bz_e, dn_e};
    endfunction

    // model: position within the current run (0 = idle)
    int phase = 0, m_len = 6, m_n = 0;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= 0;
        end else if (phase == 0) begin
            if (start) begin
                phase <= 1;
                m_n   <= int'(n_i);
                m_len <= run_len(int'(n_i));
            end
        end else if (phase == m_len) begin
            phase <= 0;
        end else begin
            phase <= phase + 1;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    logic [23:0] act_vec, mod_vec;
    always @(negedge clk) begin
        act_vec = {Data_i, IE, we, wa, rea, reb, raa, rab, Sel_alu, OE, busy, done};
        mod_vec = exp_vec(phase, m_len, m_n);
        checks++;
        if (act_vec !== mod_vec) begin
            errors++;
            $display("FAIL ctrl_vector phase=%0d n=%0d: got %h expected %h (t=%0t)",
                     phase, m_n, act_vec, mod_vec, $time);
        end
        if (!rst && phase != 0 && phase == m_len) chk("model_out", int'(out_q), fact_mod(m_n));
    end

    int rec_data [64], rec_wa [64], rec_sel [64], rec_rab [64], rec_oe [64], rec_raa [64];

    task automatic run_n(input int n, input int exp_out, input int exp_cyc, input bit noise,
                         input int pa, input int pb, input int hold_from, output int done_cyc);
        int cyc, we1_cnt;
        n_i = 8'(n);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0; we1_cnt = 0; done_cyc = -1;
        while (cyc < 1000) begin
            cyc++;
            if (cyc < 64) begin
                rec_data[cyc] = int'(Data_i); rec_wa[cyc] = int'(wa); rec_sel[cyc] = int'(Sel_alu);
                rec_rab[cyc] = int'(rab); rec_oe[cyc] = int'(OE); rec_raa[cyc] = int'(raa);
            end
            if (cyc > 2 && we && wa == 2'd1) we1_cnt++;
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (noise) begin
                start = 1'($urandom_range(0, 1));
                n_i = 8'($urandom);
            end else begin
                start = (cyc == pa || cyc == pb || (hold_from > 0 && cyc >= hold_from));
            end
            @(posedge clk); #1;
        end
        if (hold_from == 0) start = 1'b0;
        chk("done_cycle", done_cyc, exp_cyc);
        chk("out_result", int'(out_q), exp_out);
        chk("acc_writes", we1_cnt, (n >= 2) ? n - 1 : 0);
        if (hold_from == 0) begin
            @(posedge clk); #1;
            chk("done_width", int'(done), 0);
            chk("busy_after", int'(busy), 0);
        end
    endtask

    int dc, c, rn;

    initial begin
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // abort during LOAD_ONE with an asynchronous reset
        n_i = 8'd3; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        chk("in_load_one_wa", int'(wa), 1);
        #1 rst = 1'b1;
        #1;
        chk("async_reset_vec", int'({Data_i, IE, we, wa, rea, reb, raa, rab, Sel_alu, OE, busy, done}), 0);
        @(posedge clk); #2 rst = 1'b0;
        @(posedge clk); #1;

        run_n(3, 6, 12, 0, 0, 0, 0, dc);
        run_n(5, 120, 18, 0, 0, 0, 0, dc);
        run_n(0, 1, 6, 0, 0, 0, 0, dc);
        run_n(1, 1, 6, 0, 0, 0, 0, dc);
        run_n(6, 208, 21, 0, 0, 0, 0, dc);

        run_n(2, 2, 9, 0, 0, 0, 0, dc);
        chk("n2_load_n_data", rec_data[1], 2);
        chk("n2_load_n_wa", rec_wa[1], 0);
        chk("n2_mul_sel", rec_sel[5], 3);
        chk("n2_dec_rab", rec_rab[6], 2);
        chk("n2_output_oe", rec_oe[8], 1);
        chk("n2_output_raa", rec_raa[8], 1);

        // starts while busy are ignored; start held through DONE relaunches from IDLE
        run_n(4, 24, 15, 0, 5, 10, 13, dc);
        c = 15;
        do begin
            @(posedge clk); #1;
            c++;
            if (c == 17) start = 1'b0;
        end while (!done && c < 200);
        start = 1'b0;
        chk("rerun_done_cycle", c, 31);
        chk("rerun_out", int'(out_q), 24);
        @(posedge clk); #1;

        for (int i = 0; i < 24; i++) begin
            rn = ($urandom_range(0, 5) == 0) ? int'($urandom_range(8, 40)) : int'($urandom_range(0, 7));
            run_n(rn, fact_mod(rn), run_len(rn), 1, 0, 0, 0, dc);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
